// File: rtl/pep_br_modsw_gen.sv
// ---------------------------------------------------------------------------
// pep_br_modsw_gen
//
// Purpose:
//   Modulus switch from the NTT modulus MOD_NTT down to a power-of-two
//   modulus 2^k. Each lane computes
//       z = round(a * 2^k / MOD_NTT) mod 2^k
//   as a multiply by the elaboration-time constant
//   SCALE = round(2^PRECISION_W / MOD_NTT), followed by a rounding right shift
//   and a k-bit mask. A bypass mode passes the coefficient through unchanged
//   with the same latency. The target k and the bypass flag are chosen once
//   per batch and travel with every beat, so overlapping batches in the
//   pipeline can each use their own setting.
//
// Ports:
//   clk            clock
//   s_rst          synchronous active-high reset
//   in_avail       per-lane valid of the incoming beat (PSI*R lanes)
//   in_sob/in_eob  start / end of batch markers (control copies of side bits)
//   in_side        side-band carried alongside the beat
//   a              PSI*R coefficients of MOD_Q_W bits, reduced mod MOD_NTT
//   cfg_log_out    requested log2 of the output modulus (0 or >MOD_Q_W clamp)
//   cfg_bypass     pass coefficients through unchanged
//   out_avail      per-lane valid of the outgoing beat
//   out_ctrl_avail copy of lane 0 valid for control consumers
//   out_side       side-band aligned with z
//   z              switched coefficients, zero-extended to MOD_Q_W bits
//   err            sticky {lane_mismatch, sob_in_batch, eob_no_batch}
//   batch_cnt      number of batches whose eob beat has left the pipeline
//
// Latency is MULT_LAT+2 cycles: input register, MULT_LAT multiplier stages
// (MULT_LAT is expected to be 1..4), and the round/shift/mask register.
// ---------------------------------------------------------------------------
module pep_br_modsw_gen #(
    parameter int                R           = 8,
    parameter int                PSI         = 8,
    parameter int                MOD_Q_W     = 32,
    parameter logic [63:0]       MOD_NTT     = (64'd1 << 32) - (64'd1 << 17) - (64'd1 << 13) + 64'd1,
    parameter int                PRECISION_W = 64,
    parameter int                MULT_LAT    = 2,
    parameter int                BPBS_ID_W   = 4,
    parameter int                SIDE_W      = 6 + BPBS_ID_W,
    parameter logic [SIDE_W-1:0] RST_SIDE    = '0
) (
    input  logic                     clk,
    input  logic                     s_rst,
    input  logic [PSI*R-1:0]         in_avail,
    input  logic                     in_sob,
    input  logic                     in_eob,
    input  logic [SIDE_W-1:0]        in_side,
    input  logic [PSI*R*MOD_Q_W-1:0] a,
    input  logic [4:0]               cfg_log_out,
    input  logic                     cfg_bypass,
    output logic [PSI*R-1:0]         out_avail,
    output logic                     out_ctrl_avail,
    output logic [SIDE_W-1:0]        out_side,
    output logic [PSI*R*MOD_Q_W-1:0] z,
    output logic [2:0]               err,
    output logic [15:0]              batch_cnt
);

    localparam int N      = PSI * R;
    localparam int PROD_W = MOD_Q_W + PRECISION_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int KW     = $clog2(MOD_Q_W + 1);
    localparam int SH_W   = $clog2(PRECISION_W + 1);
    localparam int NUM_W  = PRECISION_W + 66;
    localparam int LAST   = MULT_LAT - 1;

    // Rounded reciprocal of the modulus: (2^P + M/2) / M, evaluated with
    // enough headroom that neither the numerator nor the modulus overflows.
    function automatic logic [PRECISION_W-1:0] calc_scale();
        logic [NUM_W-1:0] num;
        logic [NUM_W-1:0] den;
        den = NUM_W'(MOD_NTT);
        num = (NUM_W'(1) << PRECISION_W) + (den >> 1);
        return PRECISION_W'(num / den);
    endfunction

    localparam logic [PRECISION_W-1:0] SCALE = calc_scale();

    typedef enum logic [0:0] {
        IDLE,
        IN_BATCH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [KW-1:0]   lat_k;
    logic [KW-1:0]   lat_k_nxt;
    logic            lat_byp;
    logic            lat_byp_nxt;
    logic [KW-1:0]   cfg_k;
    logic [KW-1:0]   beat_k;
    logic            beat_byp;
    logic [2:0]      err_set;
    logic            beat_valid;

    // Input register stage
    logic [N-1:0]        s0_avail;
    logic                s0_eob;
    logic [SIDE_W-1:0]   s0_side;
    logic [MOD_Q_W-1:0]  s0_a [N];
    logic [KW-1:0]       s0_k;
    logic                s0_byp;

    // Multiplier stages
    logic [N-1:0]        m_avail [MULT_LAT];
    logic                m_eob   [MULT_LAT];
    logic [SIDE_W-1:0]   m_side  [MULT_LAT];
    logic [PROD_W-1:0]   m_prod  [MULT_LAT][N];
    logic [KW-1:0]       m_k     [MULT_LAT];
    logic                m_byp   [MULT_LAT];

    logic [PROD_W-1:0]   prod_c [N];
    logic [SH_W-1:0]     sh;
    logic [SUM_W-1:0]    rnd;
    logic [MOD_Q_W-1:0]  kmask;
    logic [MOD_Q_W-1:0]  res_c [N];

    assign beat_valid     = |in_avail;
    assign out_ctrl_avail = out_avail[0];

    // Requested k with out-of-range values (0 or wider than a coefficient)
    // folded back to the full coefficient width.
    always_comb begin
        cfg_k = KW'(MOD_Q_W);
        if ((cfg_log_out != 5'd0) && (int'(cfg_log_out) <= MOD_Q_W)) begin
            cfg_k = KW'(cfg_log_out);
        end
    end

    // Batch FSM and configuration selection. A sob beat uses the live cfg
    // inputs and latches them; every other beat reuses the latched copy, so
    // cfg wiggles inside a batch are invisible. Beats with no lane valid do
    // not touch the FSM or the error flags. A sob inside a batch is flagged
    // but still reloads the cfg; a lone eob outside a batch is flagged and
    // processed with whatever cfg was latched last.
    always_comb begin
        state_nxt   = state;
        lat_k_nxt   = lat_k;
        lat_byp_nxt = lat_byp;
        beat_k      = lat_k;
        beat_byp    = lat_byp;
        err_set     = 3'b000;
        if (beat_valid) begin
            if (!(&in_avail)) begin
                err_set[2] = 1'b1;
            end
            if (in_sob) begin
                beat_k      = cfg_k;
                beat_byp    = cfg_bypass;
                lat_k_nxt   = cfg_k;
                lat_byp_nxt = cfg_bypass;
                if (state == IN_BATCH) begin
                    err_set[1] = 1'b1;
                end
                state_nxt = in_eob ? IDLE : IN_BATCH;
            end else if (in_eob) begin
                if (state == IDLE) begin
                    err_set[0] = 1'b1;
                end
                state_nxt = IDLE;
            end
        end
    end

    // FSM state, latched cfg and sticky error register.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state   <= IDLE;
            lat_k   <= KW'(MOD_Q_W);
            lat_byp <= 1'b0;
            err     <= 3'b000;
        end else begin
            state   <= state_nxt;
            lat_k   <= lat_k_nxt;
            lat_byp <= lat_byp_nxt;
            err     <= err | err_set;
        end
    end

    // Pipeline valid/control bits. Side-band is reset too so out_side shows
    // RST_SIDE until real beats arrive. A reset drops every in-flight beat.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            s0_avail <= '0;
            s0_eob   <= 1'b0;
            s0_side  <= RST_SIDE;
            for (int s = 0; s < MULT_LAT; s++) begin
                m_avail[s] <= '0;
                m_eob[s]   <= 1'b0;
                m_side[s]  <= RST_SIDE;
            end
        end else begin
            s0_avail   <= in_avail;
            s0_eob     <= in_eob;
            s0_side    <= in_side;
            m_avail[0] <= s0_avail;
            m_eob[0]   <= s0_eob;
            m_side[0]  <= s0_side;
            for (int s = 1; s < MULT_LAT; s++) begin
                m_avail[s] <= m_avail[s-1];
                m_eob[s]   <= m_eob[s-1];
                m_side[s]  <= m_side[s-1];
            end
        end
    end

    // Product per lane. In bypass the coefficient rides through the product
    // register unchanged, which keeps the bypass latency identical without a
    // separate delay line.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (s0_byp) begin
                prod_c[i] = PROD_W'(s0_a[i]);
            end else begin
                prod_c[i] = PROD_W'(s0_a[i]) * PROD_W'(SCALE);
            end
        end
    end

    // Data path registers; these carry no reset since their contents only
    // matter when the matching valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            s0_a[i]      <= a[i*MOD_Q_W +: MOD_Q_W];
            m_prod[0][i] <= prod_c[i];
        end
        s0_k     <= beat_k;
        s0_byp   <= beat_byp;
        m_k[0]   <= s0_k;
        m_byp[0] <= s0_byp;
        for (int s = 1; s < MULT_LAT; s++) begin
            for (int i = 0; i < N; i++) begin
                m_prod[s][i] <= m_prod[s-1][i];
            end
            m_k[s]   <= m_k[s-1];
            m_byp[s] <= m_byp[s-1];
        end
    end

    // Rounding shift by PRECISION_W-k with a half-LSB bias, then keep k bits.
    // When k reaches PRECISION_W there is nothing to shift away, so both the
    // shift and the bias collapse to zero.
    always_comb begin
        sh  = '0;
        rnd = '0;
        if (int'(m_k[LAST]) < PRECISION_W) begin
            sh  = SH_W'(PRECISION_W - int'(m_k[LAST]));
            rnd = SUM_W'(1) << (sh - SH_W'(1));
        end
        if (int'(m_k[LAST]) >= MOD_Q_W) begin
            kmask = '1;
        end else begin
            kmask = (MOD_Q_W'(1) << m_k[LAST]) - MOD_Q_W'(1);
        end
        for (int i = 0; i < N; i++) begin
            if (m_byp[LAST]) begin
                res_c[i] = m_prod[LAST][i][MOD_Q_W-1:0];
            end else begin
                res_c[i] = MOD_Q_W'((SUM_W'(m_prod[LAST][i]) + rnd) >> sh) & kmask;
            end
        end
    end

    // Output register and completed-batch counter. Lanes without a valid bit
    // present zero so z never shows stale data.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            out_avail <= '0;
            out_side  <= RST_SIDE;
            z         <= '0;
            batch_cnt <= 16'd0;
        end else begin
            out_avail <= m_avail[LAST];
            out_side  <= m_side[LAST];
            for (int i = 0; i < N; i++) begin
                z[i*MOD_Q_W +: MOD_Q_W] <= m_avail[LAST][i] ? res_c[i] : '0;
            end
            if ((|m_avail[LAST]) && m_eob[LAST]) begin
                batch_cnt <= batch_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pep_br_modsw_gen.sv
// ---------------------------------------------------------------------------
// tb_pep_br_modsw_gen
//
// Small configuration: 4 lanes of 16-bit coefficients, MOD_NTT = 17,
// PRECISION_W = 16 (scale constant 3855), MULT_LAT = 2 so outputs appear
// four cycles after a beat is presented. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_pep_br_modsw_gen;

    localparam int LAT = 4;
    localparam logic [3:0] FULL = 4'hF;

    logic        clk = 1'b0;
    logic        s_rst;
    logic [3:0]  in_avail;
    logic        in_sob;
    logic        in_eob;
    logic [7:0]  in_side;
    logic [63:0] a;
    logic [4:0]  cfg_log_out;
    logic        cfg_bypass;
    logic [3:0]  out_avail;
    logic        out_ctrl_avail;
    logic [7:0]  out_side;
    logic [63:0] z;
    logic [2:0]  err;
    logic [15:0] batch_cnt;

    int errors = 0;
    int checks = 0;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    pep_br_modsw_gen #(
        .R           (2),
        .PSI         (2),
        .MOD_Q_W     (16),
        .MOD_NTT     (64'd17),
        .PRECISION_W (16),
        .MULT_LAT    (2),
        .BPBS_ID_W   (2),
        .SIDE_W      (8),
        .RST_SIDE    (8'hA5)
    ) dut (
        .clk            (clk),
        .s_rst          (s_rst),
        .in_avail       (in_avail),
        .in_sob         (in_sob),
        .in_eob         (in_eob),
        .in_side        (in_side),
        .a              (a),
        .cfg_log_out    (cfg_log_out),
        .cfg_bypass     (cfg_bypass),
        .out_avail      (out_avail),
        .out_ctrl_avail (out_ctrl_avail),
        .out_side       (out_side),
        .z              (z),
        .err            (err),
        .batch_cnt      (batch_cnt)
    );

    // One beat of stimulus together with what should come out LAT cycles later.
    typedef struct {
        logic [3:0]  avail;
        logic        sob;
        logic        eob;
        logic [4:0]  k;
        logic        byp;
        logic [63:0] a;
        logic [3:0]  expAvail;
        logic [63:0] expZ;
    } beat_t;

    beat_t vectors[$];

    function automatic beat_t mkBeat(input logic [3:0] av, input logic sob, input logic eob,
                                     input logic [4:0] k, input logic byp, input logic [63:0] data,
                                     input logic [3:0] expAv, input logic [63:0] expData);
        beat_t b;
        b.avail    = av;
        b.sob      = sob;
        b.eob      = eob;
        b.k        = k;
        b.byp      = byp;
        b.a        = data;
        b.expAvail = expAv;
        b.expZ     = expData;
        return b;
    endfunction

    function automatic logic [7:0] sideOf(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Compare one value and report a mismatch with both values.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one beat onto the inputs.
    task automatic applyStimulus(input beat_t b, input logic [7:0] side);
        in_avail    = b.avail;
        in_sob      = b.sob;
        in_eob      = b.eob;
        in_side     = side;
        a           = b.a;
        cfg_log_out = b.k;
        cfg_bypass  = b.byp;
    endtask

    task automatic applyIdle();
        in_avail    = 4'h0;
        in_sob      = 1'b0;
        in_eob      = 1'b0;
        in_side     = 8'h00;
        a           = 64'h0;
        cfg_log_out = 5'd0;
        cfg_bypass  = 1'b0;
    endtask

    // Drive a beat on the next falling edge, then idle and wait until its
    // output is visible.
    task automatic sendAndWait(input beat_t b);
        @(negedge clk);
        applyStimulus(b, 8'h3C);
        @(negedge clk);
        applyIdle();
        repeat (LAT - 1) @(negedge clk);
    endtask

    // Main sequence: reset, streamed vector table, error flags, reset with
    // beats in flight, and counter wrap.
    initial begin
        beat_t b;
        logic  sawAvail;

        // Single-beat batches covering several k values and clamp cases.
        vectors.push_back(mkBeat(FULL, 1, 1, 5'd4, 0, {16'd1, 16'd16, 16'd8, 16'd0},
                                 FULL, {16'd1, 16'd15, 16'd8, 16'd0}));
        vectors.push_back(mkBeat(FULL, 1, 1, 5'd8, 0, {16'd0, 16'd5, 16'd1, 16'd16},
                                 FULL, {16'd0, 16'd75, 16'd15, 16'd241}));
        vectors.push_back(mkBeat(FULL, 1, 1, 5'd1, 0, {16'd4, 16'd16, 16'd9, 16'd8},
                                 FULL, {16'd0, 16'd0, 16'd1, 16'd1}));
        vectors.push_back(mkBeat(FULL, 1, 1, 5'd0, 0, {16'd2, 16'd17, 16'd16, 16'd1},
                                 FULL, {16'd7710, 16'd65535, 16'd61680, 16'd3855}));
        vectors.push_back(mkBeat(FULL, 1, 1, 5'd20, 0, {16'd5, 16'd10, 16'd0, 16'd3},
                                 FULL, {16'd19275, 16'd38550, 16'd0, 16'd11565}));
        vectors.push_back(mkBeat(FULL, 1, 1, 5'd12, 0, {16'd17, 16'd3, 16'd1, 16'd16},
                                 FULL, {16'd0, 16'd723, 16'd241, 16'd3855}));
        vectors.push_back(mkBeat(FULL, 1, 1, 5'd4, 1, 64'hABCD_0000_FFFF_1234,
                                 FULL, 64'hABCD_0000_FFFF_1234));
        // Batch A (k=4) then batch B (k=8 only on its sob beat), no gap.
        vectors.push_back(mkBeat(FULL, 1, 0, 5'd4, 0, {4{16'd16}}, FULL, {4{16'd15}}));
        vectors.push_back(mkBeat(FULL, 0, 1, 5'd4, 0, {4{16'd16}}, FULL, {4{16'd15}}));
        vectors.push_back(mkBeat(FULL, 1, 0, 5'd8, 0, {4{16'd16}}, FULL, {4{16'd241}}));
        vectors.push_back(mkBeat(FULL, 0, 1, 5'd4, 0, {4{16'd16}}, FULL, {4{16'd241}}));
        // cfg toggled mid-batch: every beat keeps k=4, non-bypass.
        vectors.push_back(mkBeat(FULL, 1, 0, 5'd4, 0, {16'd8, 16'd8, 16'd8, 16'd16},
                                 FULL, {16'd8, 16'd8, 16'd8, 16'd15}));
        vectors.push_back(mkBeat(FULL, 0, 0, 5'd8, 1, {16'd8, 16'd8, 16'd8, 16'd16},
                                 FULL, {16'd8, 16'd8, 16'd8, 16'd15}));
        vectors.push_back(mkBeat(FULL, 0, 0, 5'd1, 0, {16'd8, 16'd8, 16'd8, 16'd16},
                                 FULL, {16'd8, 16'd8, 16'd8, 16'd15}));
        vectors.push_back(mkBeat(FULL, 0, 1, 5'd0, 1, {16'd8, 16'd8, 16'd8, 16'd16},
                                 FULL, {16'd8, 16'd8, 16'd8, 16'd15}));
        // Empty beat with stray markers: ignored entirely.
        vectors.push_back(mkBeat(4'h0, 1, 1, 5'd8, 0, 64'h0, 4'h0, 64'h0));
        // Bypass batch; the eob beat's cfg is ignored.
        vectors.push_back(mkBeat(FULL, 1, 0, 5'd4, 1, {4{16'h1234}}, FULL, {4{16'h1234}}));
        vectors.push_back(mkBeat(FULL, 0, 1, 5'd1, 0, 64'h1234_FFFF_00FF_0001,
                                 FULL, 64'h1234_FFFF_00FF_0001));

        // Reset behaviour during and right after reset.
        applyIdle();
        s_rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst out_avail", 64'(out_avail), 64'h0);
        checkOutput("rst out_side", 64'(out_side), 64'hA5);
        checkOutput("rst z", z, 64'h0);
        checkOutput("rst err", 64'(err), 64'h0);
        checkOutput("rst batch_cnt", 64'(batch_cnt), 64'h0);
        s_rst = 1'b0;
        @(negedge clk);
        checkOutput("post-rst out_avail", 64'(out_avail), 64'h0);
        checkOutput("post-rst ctrl_avail", 64'(out_ctrl_avail), 64'h0);
        checkOutput("post-rst out_side", 64'(out_side), 64'hA5);
        checkOutput("post-rst z", z, 64'h0);

        // Stream the table back to back and compare each output LAT later.
        for (int i = 0; i < vectors.size() + LAT; i++) begin
            @(negedge clk);
            if (i == LAT - 1) begin
                checkOutput("pre-latency out_avail", 64'(out_avail), 64'h0);
            end
            if (i >= LAT) begin
                b = vectors[i - LAT];
                checkOutput($sformatf("vec%0d out_avail", i - LAT), 64'(out_avail), 64'(b.expAvail));
                checkOutput($sformatf("vec%0d ctrl_avail", i - LAT), 64'(out_ctrl_avail), 64'(b.expAvail[0]));
                if (b.expAvail != 4'h0) begin
                    checkOutput($sformatf("vec%0d z", i - LAT), z, b.expZ);
                    checkOutput($sformatf("vec%0d out_side", i - LAT), 64'(out_side), 64'(sideOf(i - LAT)));
                end
            end
            if (i < vectors.size()) begin
                applyStimulus(vectors[i], sideOf(i));
            end else begin
                applyIdle();
            end
        end
        checkOutput("stream batch_cnt", 64'(batch_cnt), 64'd11);
        checkOutput("stream err", 64'(err), 64'h0);

        // Lane mismatch: flag appears the next cycle and stays.
        @(negedge clk);
        applyStimulus(mkBeat(4'h1, 0, 0, 5'd4, 0, 64'h8, 4'h1, 64'h8), 8'h00);
        @(negedge clk);
        applyIdle();
        checkOutput("lane mismatch err", 64'(err), 64'h4);
        repeat (LAT - 1) @(negedge clk);
        checkOutput("partial out_avail", 64'(out_avail), 64'h1);
        checkOutput("partial ctrl_avail", 64'(out_ctrl_avail), 64'h1);
        checkOutput("partial z", z, 64'h8);
        checkOutput("lane mismatch sticky", 64'(err), 64'h4);

        // sob inside a batch, then a legal eob, then a lone eob in IDLE.
        @(negedge clk);
        applyStimulus(mkBeat(FULL, 1, 0, 5'd4, 0, 64'h0, FULL, 64'h0), 8'h00);
        @(negedge clk);
        applyStimulus(mkBeat(FULL, 1, 0, 5'd4, 0, 64'h0, FULL, 64'h0), 8'h00);
        @(negedge clk);
        applyIdle();
        checkOutput("sob in batch err", 64'(err), 64'h6);
        @(negedge clk);
        applyStimulus(mkBeat(FULL, 0, 1, 5'd4, 0, 64'h0, FULL, 64'h0), 8'h00);
        @(negedge clk);
        applyIdle();
        checkOutput("legal eob err", 64'(err), 64'h6);
        @(negedge clk);
        applyStimulus(mkBeat(FULL, 0, 1, 5'd4, 0, 64'h0, FULL, 64'h0), 8'h00);
        @(negedge clk);
        applyIdle();
        checkOutput("eob in idle err", 64'(err), 64'h7);
        repeat (LAT) @(negedge clk);

        // Reset with two beats in flight; FSM left IN_BATCH with k=8 latched.
        @(negedge clk);
        applyStimulus(mkBeat(FULL, 1, 1, 5'd8, 0, {4{16'd16}}, FULL, 64'h0), 8'h00);
        @(negedge clk);
        applyStimulus(mkBeat(FULL, 1, 0, 5'd8, 1, {4{16'd16}}, FULL, 64'h0), 8'h00);
        @(negedge clk);
        applyIdle();
        s_rst = 1'b1;
        repeat (2) @(negedge clk);
        s_rst = 1'b0;
        sawAvail = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            sawAvail = sawAvail | (|out_avail);
        end
        checkOutput("flushed out_avail", 64'(sawAvail), 64'h0);
        checkOutput("flushed batch_cnt", 64'(batch_cnt), 64'h0);
        checkOutput("flushed err", 64'(err), 64'h0);

        // Lone eob right after reset: FSM must be IDLE and cfg k=16, no bypass.
        sendAndWait(mkBeat(FULL, 0, 1, 5'd3, 1, {16'd17, 16'd2, 16'd16, 16'd1}, FULL, 64'h0));
        checkOutput("reset cfg z", z, {16'd65535, 16'd7710, 16'd61680, 16'd3855});
        checkOutput("reset fsm err", 64'(err), 64'h1);
        checkOutput("reset batch_cnt", 64'(batch_cnt), 64'd1);

        // Run the counter up to 0xFFFF, then one more batch wraps it to 0.
        for (int i = 0; i < 65534; i++) begin
            @(negedge clk);
            applyStimulus(mkBeat(FULL, 1, 1, 5'd4, 0, 64'h0, FULL, 64'h0), 8'h00);
        end
        @(negedge clk);
        applyIdle();
        repeat (LAT - 1) @(negedge clk);
        checkOutput("batch_cnt max", 64'(batch_cnt), 64'hFFFF);
        sendAndWait(mkBeat(FULL, 1, 1, 5'd4, 0, {4{16'd16}}, FULL, 64'h0));
        checkOutput("batch_cnt wrap", 64'(batch_cnt), 64'h0);
        checkOutput("wrap beat z", z, {4{16'd15}});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
